// File: rtl/can_mcif_pkg.sv
// can_mcif_pkg: shared types and constants for the CAN microcontroller interface channels
package can_mcif_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} rd_state_e;
  typedef enum logic [1:0] {RD_OK = 2'b00, RD_DECERR = 2'b01, RD_TIMEOUT = 2'b10} rd_status_e;
  localparam logic [63:0] CAN_RD_VALID_MAP = 64'h0000_0001_FFF0_01FF;
endpackage

// File: rtl/can_mcif_addr_dec.sv
// can_mcif_addr_dec: address to one-hot select plus readable/read-to-clear lookup
module can_mcif_addr_dec #(
  parameter int ADDR_W = 6,
  parameter logic [(1<<ADDR_W)-1:0] VALID_MAP = '1,
  parameter logic [(1<<ADDR_W)-1:0] RC_MAP = '0
) (
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [(1<<ADDR_W)-1:0] o_onehot,
  output logic                   o_valid,
  output logic                   o_rc
);
  localparam int N = 1 << ADDR_W;
  assign o_onehot = N'(1) << i_addr;
  assign o_valid  = VALID_MAP[i_addr];
  assign o_rc     = RC_MAP[i_addr];
endmodule

// File: rtl/can_mcif_rd_channel.sv
// can_mcif_rd_channel: registered read channel with address check, bank ack timeout and read-to-clear strobe
module can_mcif_rd_channel
  import can_mcif_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter logic [(1<<ADDR_W)-1:0] VALID_MAP = CAN_RD_VALID_MAP,
  parameter logic [(1<<ADDR_W)-1:0] RC_MAP = '0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rd_en,
  input  logic                   i_rd_req,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic                   o_rd_ready,
  output logic [(1<<ADDR_W)-1:0] o_reg_sel,
  input  logic                   i_ack,
  input  logic [DATA_W-1:0]      i_reg_r_data,
  output logic                   o_rd_valid,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic [1:0]             o_rd_status,
  output logic [(1<<ADDR_W)-1:0] o_rc_strobe
);
  localparam int N = 1 << ADDR_W;
  localparam int CW = ACK_TIMEOUT == 0 ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(ACK_TIMEOUT == 0 ? 0 : ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = '1;
  rd_state_e r_state, w_state;
  rd_status_e r_status, w_status;
  logic [ADDR_W-1:0] r_addr, w_addr, w_dec_addr;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [N-1:0] r_reg_sel, w_reg_sel, r_rc_strobe, w_rc_strobe, w_sel;
  logic [DATA_W-1:0] r_data, w_data;
  logic r_valid, w_valid, w_map_valid, w_map_rc;
  // one decoder serves both the incoming address (IDLE) and the latched one
  assign w_dec_addr = r_state == IDLE ? i_addr : r_addr;
  can_mcif_addr_dec #(.ADDR_W(ADDR_W), .VALID_MAP(VALID_MAP), .RC_MAP(RC_MAP)) u_dec (
    .i_addr  (w_dec_addr),
    .o_onehot(w_sel),
    .o_valid (w_map_valid),
    .o_rc    (w_map_rc)
  );
  always_comb begin
    w_state = r_state;
    w_addr = r_addr;
    w_cnt = r_cnt;
    w_reg_sel = '0;
    w_valid = 1'b0;
    w_data = '0;
    w_status = RD_OK;
    w_rc_strobe = '0;
    unique case (r_state)
      IDLE: if (i_rd_req && i_rd_en) begin
        w_addr = i_addr;
        w_cnt = '0;
        w_state = w_map_valid ? WAIT_ACK : RESP;
        w_reg_sel = w_map_valid ? w_sel : '0;
        w_valid = !w_map_valid;
        w_status = w_map_valid ? RD_OK : RD_DECERR;
      end
      WAIT_ACK: begin
        w_cnt = r_cnt + CW'(r_cnt != CMAX);
        if (i_ack) begin
          w_state = RESP;
          w_valid = 1'b1;
          w_data = i_reg_r_data;
          w_rc_strobe = w_map_rc ? w_sel : '0;
        end else if (ACK_TIMEOUT != 0 && r_cnt == TMAX) begin
          w_state = RESP;
          w_valid = 1'b1;
          w_status = RD_TIMEOUT;
        end else w_reg_sel = w_sel;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_cnt <= '0;
      r_reg_sel <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_status <= RD_OK;
      r_rc_strobe <= '0;
    end else begin
      r_state <= w_state;
      r_addr <= w_addr;
      r_cnt <= w_cnt;
      r_reg_sel <= w_reg_sel;
      r_valid <= w_valid;
      r_data <= w_data;
      r_status <= w_status;
      r_rc_strobe <= w_rc_strobe;
    end
  end
  assign o_rd_ready = r_state == IDLE;
  assign o_reg_sel = r_reg_sel;
  assign o_rd_valid = r_valid;
  assign o_rd_data = r_data;
  assign o_rd_status = r_status;
  assign o_rc_strobe = r_rc_strobe;
endmodule

// File: tb/tb_can_mcif_rd_channel.sv
// tb_can_mcif_rd_channel: scoreboard bench with a transaction-level reference model
module tb_can_mcif_rd_channel;
  localparam int T = 15;
  localparam logic [63:0] RC = 64'h0000_0001_0010_0009;
  logic clk = 0, rst = 1, rd_en = 0, rd_req = 0, ack = 0;
  logic [5:0] addr = '0;
  logic [31:0] rdata = '0;
  logic rd_ready, rd_valid;
  logic [63:0] reg_sel, rc_strobe;
  logic [31:0] rd_data;
  logic [1:0] rd_status;
  int cyc = 0, n_run = 0, n_fail = 0;
  typedef struct {logic [31:0] d; logic [1:0] s; logic [63:0] rc; int c;} exp_t;
  exp_t q[$];

  can_mcif_rd_channel #(.ACK_TIMEOUT(T), .RC_MAP(RC)) dut (
    .i_clk(clk), .i_reset(rst), .i_rd_en(rd_en), .i_rd_req(rd_req), .i_addr(addr),
    .o_rd_ready(rd_ready), .o_reg_sel(reg_sel), .i_ack(ack), .i_reg_r_data(rdata),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_status(rd_status), .o_rc_strobe(rc_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit readable(input logic [5:0] a);
    return (a <= 6'd8) || (a >= 6'd20 && a <= 6'd32);
  endfunction

  // response predicted from the address class and the WAIT cycle in which ack first appears
  function automatic exp_t model(input logic [5:0] a, input int k, input logic [31:0] d, input int c);
    exp_t e;
    e.d = '0;
    e.rc = '0;
    if (!readable(a)) begin
      e.s = 2'b01;
      e.c = c + 1;
    end else if (k <= T) begin
      e.s = 2'b00;
      e.d = d;
      e.c = c + 1 + k;
      if (RC[a]) e.rc = 64'd1 << a;
    end else begin
      e.s = 2'b10;
      e.c = c + 1 + T;
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (rd_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 64'(rd_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.c));
          chk("resp_data", 64'(rd_data), 64'(e.d));
          chk("resp_status", 64'(rd_status), 64'(e.s));
          chk("resp_rc_strobe", rc_strobe, e.rc);
        end
      end else begin
        chk("idle_strobe", rc_strobe, 64'd0);
        chk("idle_data_status", {30'd0, rd_data, rd_status}, 64'd0);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 40 && !rd_ready; i++) @(posedge clk) #1;
    chk("ready_before_req", 64'(rd_ready), 64'd1);
  endtask

  task automatic do_read(input logic [5:0] a, input int k, input logic [31:0] d);
    wait_ready();
    rd_en = 1;
    rd_req = 1;
    addr = a;
    q.push_back(model(a, k, d, cyc));
    @(posedge clk) #1;
    rd_req = 0;
    addr = 6'($urandom);
    if (readable(a))
      for (int j = 1; j <= T; j++) begin
        chk("wait_reg_sel", reg_sel, 64'd1 << a);
        chk("wait_not_ready", 64'(rd_ready), 64'd0);
        ack = (j == k);
        rdata = (j == k) ? d : $urandom;
        rd_en = 1'($urandom);
        @(posedge clk) #1;
        if (j == k) break;
      end
    chk("resp_reg_sel", reg_sel, 64'd0);
    chk("resp_not_ready", 64'(rd_ready), 64'd0);
    ack = 1;
    rdata = $urandom;
    rd_en = 1;
    @(posedge clk) #1;
    ack = 0;
  endtask

  task automatic probe_no_en();
    rd_en = 0;
    rd_req = 1;
    addr = 6'($urandom);
    ack = 1;
    @(posedge clk) #1;
    chk("disabled_ready", 64'(rd_ready), 64'd1);
    chk("disabled_sel", reg_sel, 64'd0);
    rd_req = 0;
    ack = 0;
    rd_en = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_ready", 64'(rd_ready), 64'd1);
    chk("reset_sel", reg_sel, 64'd0);
    chk("reset_valid", 64'(rd_valid), 64'd0);
    chk("reset_data_status", {30'd0, rd_data, rd_status}, 64'd0);
    chk("reset_strobe", rc_strobe, 64'd0);
    do_read(6'h03, 1, 32'hDEAD_BEEF);
    do_read(6'h0A, 1, 32'h1111_1111);
    do_read(6'h14, 99, 32'h2222_2222);
    do_read(6'h03, 1, 32'h5);
    do_read(6'h03, 99, 32'h5);
    do_read(6'h03, T, 32'h1234_5678);
    probe_no_en();
    wait_ready();
    rd_en = 1;
    rd_req = 1;
    addr = 6'h14;
    @(posedge clk) #1;
    rd_req = 0;
    @(posedge clk) #1;
    rst = 1;
    @(posedge clk) #1;
    rst = 0;
    chk("abort_ready", 64'(rd_ready), 64'd1);
    chk("abort_sel", reg_sel, 64'd0);
    chk("abort_valid", 64'(rd_valid), 64'd0);
    chk("abort_strobe", rc_strobe, 64'd0);
    do_read(6'h20, 1, 32'hCAFE_F00D);
    do_read(6'h00, 1, 32'hA0A0_0000);
    do_read(6'h01, 1, 32'hA0A0_0001);
    do_read(6'h1F, 1, 32'hA0A0_001F);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) probe_no_en();
      do_read(6'($urandom), int'($urandom_range(1, T + 3)), $urandom);
    end
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
